// File: rtl/mips_hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
//   hz_slot_t : one in-flight slot {valid, dst, lat}. Fields are sized to the
//               package maxima so one type serves every parameterisation;
//               RAW must not exceed HZ_RAW_MAX and LATW must not exceed HZ_LAT_MAX.
//   SEL_RF    : bypass-select code meaning "read the register file".
//   clamp_lat : maps a raw latency onto the legal range 1..depth.
package mips_hazard_pkg;

  localparam int HZ_RAW_MAX = 8;
  localparam int HZ_LAT_MAX = 8;
  localparam int SEL_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic [HZ_RAW_MAX-1:0] dst;
    logic [HZ_LAT_MAX-1:0] lat;
  } hz_slot_t;

  function automatic int clamp_lat(input int lat, input int depth);
    if (lat == 0)     return 1;
    if (lat > depth)  return depth;
    return lat;
  endfunction

endpackage

// File: rtl/hz_src_match.sv
// Priority encoder for one source operand over the in-flight slots.
//   src      : source register address (register 0 never matches)
//   slot_vld : per-slot valid, bit i = slot i+1
//   slot_dst : per-slot destination, package-max width per slot
//   slot_lat : per-slot result latency, package-max width per slot
//   hit      : some valid slot writes src
//   k        : 1-based index of the youngest matching slot
//   hazard   : youngest producer's result is not yet bypassable (k < lat)
module hz_src_match import mips_hazard_pkg::*; #(
  parameter int RAW   = 5,
  parameter int DEPTH = 3,
  parameter int SELW  = 2
) (
  input  logic [RAW-1:0]              src,
  input  logic [DEPTH-1:0]            slot_vld,
  input  logic [DEPTH*HZ_RAW_MAX-1:0] slot_dst,
  input  logic [DEPTH*HZ_LAT_MAX-1:0] slot_lat,
  output logic                        hit,
  output logic [SELW-1:0]             k,
  output logic                        hazard
);

  logic [HZ_RAW_MAX-1:0] src_x;
  assign src_x = HZ_RAW_MAX'(src);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit    = 1'b0;
    k      = '0;
    hazard = 1'b0;
    for (int i = DEPTH; i >= 1; i--) begin
      if (src != '0 && slot_vld[i-1] &&
          slot_dst[(i-1)*HZ_RAW_MAX +: HZ_RAW_MAX] == src_x) begin
        hit    = 1'b1;
        k      = SELW'(i);
        hazard = HZ_LAT_MAX'(i) < slot_lat[(i-1)*HZ_LAT_MAX +: HZ_LAT_MAX];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller between ID and EX.
//   clk, reset   : rising-edge clock, synchronous active-low reset
//   id_*         : instruction in ID (valid, NSRC sources, dst, write-enable, latency)
//   flush        : redirect; kills the ID instruction and the youngest FLUSH_DEPTH slots
//   stall        : combinational hold request for PC and IF/ID
//   ex_valid     : registered, EX holds an issued instruction
//   ex_fwd_sel   : registered per-operand bypass select (0 = RF, k = slot k)
//   stall_count  : saturating count of stalled cycles
module hazard_scoreboard import mips_hazard_pkg::*; #(
  parameter int NSRC        = 2,
  parameter int RAW         = 5,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int LATW        = $clog2(DEPTH+1),
  parameter int SELW        = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [NSRC*RAW-1:0]  id_src,
  input  logic [RAW-1:0]       id_dst,
  input  logic                 id_we,
  input  logic [LATW-1:0]      id_lat,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [NSRC*SELW-1:0] ex_fwd_sel,
  output logic [31:0]          stall_count
);

  // slot_q[i] is slot i+1 (slot 1 = EX).
  hz_slot_t slot_q [DEPTH];

  logic [DEPTH-1:0]            slot_vld;
  logic [DEPTH*HZ_RAW_MAX-1:0] slot_dst;
  logic [DEPTH*HZ_LAT_MAX-1:0] slot_lat;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign slot_vld[i]                            = slot_q[i].valid;
    assign slot_dst[i*HZ_RAW_MAX +: HZ_RAW_MAX]   = slot_q[i].dst;
    assign slot_lat[i*HZ_LAT_MAX +: HZ_LAT_MAX]   = slot_q[i].lat;
  end

  logic [NSRC-1:0]            hit, haz;
  logic [NSRC-1:0][SELW-1:0]  k_arr, fwd_sel_d;
  logic                       accept;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    hz_src_match #(.RAW(RAW), .DEPTH(DEPTH), .SELW(SELW)) u_match (
      .src      (id_src[s*RAW +: RAW]),
      .slot_vld (slot_vld),
      .slot_dst (slot_dst),
      .slot_lat (slot_lat),
      .hit      (hit[s]),
      .k        (k_arr[s]),
      .hazard   (haz[s])
    );
    // A producer in the last slot retires this edge, so the RF already has it.
    assign fwd_sel_d[s] = (accept && hit[s] && k_arr[s] <= SELW'(DEPTH-1))
                          ? k_arr[s] + SELW'(1) : SELW'(SEL_RF);
  end

  // Flush overrides stall.
  assign stall  = id_valid & ~flush & (|haz);
  assign accept = id_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      ex_valid    <= 1'b0;
      ex_fwd_sel  <= '0;
      stall_count <= '0;
    end else begin
      slot_q[0].valid <= accept & id_we & (id_dst != '0);
      slot_q[0].dst   <= HZ_RAW_MAX'(id_dst);
      slot_q[0].lat   <= HZ_LAT_MAX'(clamp_lat(int'(id_lat), DEPTH));
      for (int i = 1; i < DEPTH; i++) begin
        slot_q[i] <= slot_q[i-1];
        // Source slot number is i (1-based); kill it if it is among the youngest.
        if (flush && i <= FLUSH_DEPTH) slot_q[i].valid <= 1'b0;
      end
      ex_valid   <= accept;
      ex_fwd_sel <= fwd_sel_d;
      if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk, reset, id_valid, id_we, flush;
  logic [9:0]  id_src;
  logic [4:0]  id_dst;
  logic [1:0]  id_lat;
  logic        stall, ex_valid;
  logic [3:0]  ex_fwd_sel;
  logic [31:0] stall_count;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
    .id_dst(id_dst), .id_we(id_we), .id_lat(id_lat), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_fwd_sel(ex_fwd_sel),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] s0, s1, d; logic we; logic [1:0] lat; logic fl;
    logic stl; logic exv; logic [1:0] sel0, sel1; logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic exv; logic [3:0] sel; logic [31:0] cnt; int id;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [4:0] d, input logic we, input logic [1:0] lat,
                              input logic fl, input logic stl, input logic exv,
                              input logic [1:0] sel0, input logic [1:0] sel1,
                              input logic [31:0] cnt);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.d = d; r.we = we; r.lat = lat; r.fl = fl;
    r.stl = stl; r.exv = exv; r.sel0 = sel0; r.sel1 = sel1; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one ID cycle, check the combinational stall, queue the registered
  // expectations and compare them after the edge.
  task automatic step(input vec_t v, input int id);
    exp_t e;
    id_valid = v.v; id_src = {v.s1, v.s0}; id_dst = v.d; id_we = v.we;
    id_lat = v.lat; flush = v.fl;
    #1;
    check($sformatf("stall[%0d]", id), {31'd0, stall}, {31'd0, v.stl});
    e.exv = v.exv; e.sel = {v.sel1, v.sel0}; e.cnt = v.cnt; e.id = id;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard[%0d]: queue empty", id);
    end else begin
      e = sbq.pop_front();
      check($sformatf("ex_valid[%0d]", e.id), {31'd0, ex_valid}, {31'd0, e.exv});
      check($sformatf("ex_fwd_sel[%0d]", e.id), {28'd0, ex_fwd_sel}, {28'd0, e.sel});
      check($sformatf("stall_count[%0d]", e.id), stall_count, e.cnt);
    end
  endtask

  initial begin
    //            v  s0  s1  d  we lat fl | stl exv sel0 sel1 cnt
    vecs.push_back(mk(1, 0,  0,  5, 1, 1, 0,  0, 1, 0, 0, 0)); // ALU producer r5
    vecs.push_back(mk(1, 5,  0,  6, 1, 1, 0,  0, 1, 2, 0, 0)); // r5 from EX
    vecs.push_back(mk(1, 0,  5,  7, 1, 1, 0,  0, 1, 0, 3, 0)); // r5 from MEM
    vecs.push_back(mk(1, 5,  0,  0, 1, 1, 0,  0, 1, 0, 0, 0)); // r5 in WB -> RF; dst r0
    vecs.push_back(mk(1, 0,  0,  8, 1, 2, 0,  0, 1, 0, 0, 0)); // load r8
    vecs.push_back(mk(1, 0,  8,  9, 1, 1, 0,  1, 0, 0, 0, 1)); // load-use stall
    vecs.push_back(mk(1, 0,  8,  9, 1, 1, 0,  0, 1, 0, 3, 1)); // issues from WB
    vecs.push_back(mk(1, 0,  0,  0, 1, 1, 0,  0, 1, 0, 0, 1)); // dst r0
    vecs.push_back(mk(1, 0,  0,  1, 0, 1, 0,  0, 1, 0, 0, 1)); // src r0
    vecs.push_back(mk(1, 0,  0,  4, 1, 1, 0,  0, 1, 0, 0, 1)); // older r4
    vecs.push_back(mk(1, 0,  0,  4, 1, 1, 0,  0, 1, 0, 0, 1)); // younger r4
    vecs.push_back(mk(1, 4,  4, 10, 1, 1, 0,  0, 1, 2, 2, 1)); // youngest wins
    vecs.push_back(mk(1, 0,  0,  8, 1, 2, 0,  0, 1, 0, 0, 1)); // load r8
    vecs.push_back(mk(1, 0,  8, 11, 1, 1, 1,  0, 0, 0, 0, 1)); // flush beats stall
    vecs.push_back(mk(1, 0,  8, 12, 1, 1, 0,  0, 1, 0, 0, 1)); // r8 flushed -> RF
    vecs.push_back(mk(1, 0,  0, 13, 1, 3, 0,  0, 1, 0, 0, 1)); // lat 3 producer
    vecs.push_back(mk(1, 13, 0, 14, 1, 1, 0,  1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 13, 0, 14, 1, 1, 0,  1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 13, 0, 14, 1, 1, 0,  0, 1, 0, 0, 3)); // from WB -> RF
    vecs.push_back(mk(1, 0,  0, 15, 1, 0, 0,  0, 1, 0, 0, 3)); // lat 0 clamps to 1
    vecs.push_back(mk(1, 15, 14, 0, 0, 1, 0,  0, 1, 2, 3, 3));
    vecs.push_back(mk(1, 0,  0, 16, 1, 2, 0,  0, 1, 0, 0, 3)); // load r16
    vecs.push_back(mk(0, 16, 0,  0, 0, 1, 0,  0, 0, 0, 0, 3)); // no ID instr, no stall
    vecs.push_back(mk(1, 16, 16,17, 1, 1, 0,  0, 1, 3, 3, 3));
    vecs.push_back(mk(1, 0,  0, 18, 1, 2, 0,  0, 1, 0, 0, 3)); // load r18
    vecs.push_back(mk(1, 18, 17,19, 1, 1, 0,  1, 0, 0, 0, 4)); // one operand stalls all
    vecs.push_back(mk(1, 18, 17,19, 1, 1, 0,  0, 1, 3, 0, 4));

    // Reset with random inputs for two edges.
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      id_valid = 1'($urandom); id_src = 10'($urandom); id_dst = 5'($urandom);
      id_we = 1'($urandom); id_lat = 2'($urandom); flush = 1'($urandom);
      @(posedge clk); #1;
    end
    check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset ex_fwd_sel", {28'd0, ex_fwd_sel}, 32'd0);
    check("reset stall_count", stall_count, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset mid-operation discards an in-flight load.
    step(mk(1, 0, 0, 20, 1, 2, 0, 0, 1, 0, 0, 4), 100);
    reset = 1'b0; id_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset ex_valid", {31'd0, ex_valid}, 32'd0);
    check("midreset stall_count", stall_count, 32'd0);
    step(mk(1, 20, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), 101);

    // Saturation.
    force dut.stall_count = 32'hFFFF_FFFE;
    #1 release dut.stall_count;
    #1 check("forced stall_count", stall_count, 32'hFFFF_FFFE);
    step(mk(1, 0,  0, 21, 1, 3, 0, 0, 1, 0, 0, 32'hFFFF_FFFE), 200);
    step(mk(1, 21, 0, 23, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF), 201);
    step(mk(1, 21, 0, 23, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF), 202);
    step(mk(1, 21, 0, 22, 1, 2, 0, 0, 1, 0, 0, 32'hFFFF_FFFF), 203);
    step(mk(1, 22, 0,  0, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF), 204);
    step(mk(1, 22, 0,  0, 1, 1, 0, 0, 1, 3, 0, 32'hFFFF_FFFF), 205);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
